// File: rtl/sv39_ptw.sv
// Sv39 hardware page-table walker.
// Walks the 3-level Sv39 table for one TLB miss at a time. It issues one 8-byte PTE read per
// level, checks each returned PTE and reports a compact leaf PTE with its level, or a fault.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   req_*                       walk request from the TLB-miss arbiter (valid/ready)
//   flush                       kill any walk in progress and drop any pending result
//   mem_req_* / mem_resp_*      PTE read port towards L2 (at most one read outstanding)
//   resp_*                      walk result towards the TLB (valid/ready)
// Small PTE layout (resp_pte): {ppn[26:0], d, a, g, u, x, w, r, v}.
module sv39_ptw #(
  parameter int unsigned VA_WIDTH   = 39,
  parameter int unsigned PA_WIDTH   = 39,
  parameter int unsigned ASID_WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [VA_WIDTH-13:0]    req_vpn,
  input  logic [ASID_WIDTH-1:0]   req_asid,
  input  logic [PA_WIDTH-13:0]    req_root_ppn,
  input  logic                    flush,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [PA_WIDTH-1:0]     mem_req_pa,
  input  logic                    mem_resp_valid,
  input  logic [63:0]             mem_resp_pte,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [VA_WIDTH-13:0]    resp_vpn,
  output logic [ASID_WIDTH-1:0]   resp_asid,
  output logic [PA_WIDTH-5:0]     resp_pte,
  output logic [1:0]              resp_level,
  output logic                    resp_page_fault,
  output logic                    resp_access_fault
);

  localparam int unsigned VpnW = VA_WIDTH - 12;
  localparam int unsigned PpnW = PA_WIDTH - 12;

  typedef enum logic [1:0] {StIdle, StMreq, StMwait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  kill_q, kill_d;
  logic [1:0]            level_q, level_d;
  logic [PpnW-1:0]       table_ppn_q, table_ppn_d;
  logic [VpnW-1:0]       vpn_q, vpn_d;
  logic [ASID_WIDTH-1:0] asid_q, asid_d;
  logic                  req_ready_q, req_ready_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic [PA_WIDTH-1:0]   mem_req_pa_q, mem_req_pa_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [VpnW-1:0]       resp_vpn_q, resp_vpn_d;
  logic [ASID_WIDTH-1:0] resp_asid_q, resp_asid_d;
  logic [PpnW+7:0]       resp_pte_q, resp_pte_d;
  logic [1:0]            resp_level_q, resp_level_d;
  logic                  resp_pf_q, resp_pf_d;
  logic                  resp_af_q, resp_af_d;

  // Decoded fields of the returned PTE.
  logic            pte_v, pte_r, pte_w, pte_x;
  logic            chk_pf, chk_af, chk_leaf, chk_misaligned;
  logic [PpnW-1:0] pte_ppn;
  logic            unused_rsw;

  assign pte_v      = mem_resp_pte[0];
  assign pte_r      = mem_resp_pte[1];
  assign pte_w      = mem_resp_pte[2];
  assign pte_x      = mem_resp_pte[3];
  assign pte_ppn    = mem_resp_pte[10 +: PpnW];
  assign unused_rsw = ^mem_resp_pte[9:8];

  // N, PBMT and reserved bits live in [63:54].
  assign chk_pf   = ~pte_v | (~pte_r & pte_w) | (|mem_resp_pte[63:54]);
  // PPN2 bits above the 27-bit physical PPN.
  assign chk_af   = |mem_resp_pte[53:37];
  assign chk_leaf = pte_r | pte_x;
  assign chk_misaligned = ((level_q == 2'd2) && (|mem_resp_pte[27:10])) ||
                          ((level_q == 2'd1) && (|mem_resp_pte[18:10]));

  function automatic logic [8:0] vpn_slice(input logic [VpnW-1:0] vpn, input logic [1:0] lvl);
    case (lvl)
      2'd2:    vpn_slice = vpn[26:18];
      2'd1:    vpn_slice = vpn[17:9];
      default: vpn_slice = vpn[8:0];
    endcase
  endfunction

  always_comb begin
    state_d         = state_q;
    kill_d          = kill_q;
    level_d         = level_q;
    table_ppn_d     = table_ppn_q;
    vpn_d           = vpn_q;
    asid_d          = asid_q;
    req_ready_d     = req_ready_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_pa_d    = mem_req_pa_q;
    resp_valid_d    = resp_valid_q;
    resp_vpn_d      = resp_vpn_q;
    resp_asid_d     = resp_asid_q;
    resp_pte_d      = resp_pte_q;
    resp_level_d    = resp_level_q;
    resp_pf_d       = resp_pf_q;
    resp_af_d       = resp_af_q;

    unique case (state_q)
      StIdle: begin
        // A flush in the same cycle as the handshake cancels the request.
        if (req_valid && !flush) begin
          vpn_d           = req_vpn;
          asid_d          = req_asid;
          level_d         = 2'd2;
          table_ppn_d     = req_root_ppn;
          req_ready_d     = 1'b0;
          mem_req_valid_d = 1'b1;
          mem_req_pa_d    = {req_root_ppn, vpn_slice(req_vpn, 2'd2), 3'b000};
          state_d         = StMreq;
        end
      end
      StMreq: begin
        if (mem_req_ready) begin
          // Read is committed; a simultaneous flush must still absorb its data.
          mem_req_valid_d = 1'b0;
          kill_d          = flush;
          state_d         = StMwait;
        end else if (flush) begin
          mem_req_valid_d = 1'b0;
          req_ready_d     = 1'b1;
          state_d         = StIdle;
        end
      end
      StMwait: begin
        if (flush) kill_d = 1'b1;
        if (mem_resp_valid) begin
          if (kill_q || flush) begin
            kill_d      = 1'b0;
            req_ready_d = 1'b1;
            state_d     = StIdle;
          end else if (!chk_pf && !chk_af && !chk_leaf && (level_q != 2'd0)) begin
            level_d         = level_q - 2'd1;
            table_ppn_d     = pte_ppn;
            mem_req_valid_d = 1'b1;
            mem_req_pa_d    = {pte_ppn, vpn_slice(vpn_q, level_q - 2'd1), 3'b000};
            state_d         = StMreq;
          end else begin
            resp_valid_d = 1'b1;
            resp_vpn_d   = vpn_q;
            resp_asid_d  = asid_q;
            resp_level_d = level_q;
            resp_af_d    = ~chk_pf & chk_af;
            // Remaining cases are all page faults: bad encoding, misaligned superpage,
            // or a pointer at level 0.
            resp_pf_d    = chk_pf | (~chk_af & (chk_leaf ? chk_misaligned : 1'b1));
            resp_pte_d   = '0;
            if (!chk_pf && !chk_af && chk_leaf && !chk_misaligned) begin
              resp_pte_d = {pte_ppn, mem_resp_pte[7:0]};
            end
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (flush || resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= StIdle;
      kill_q          <= 1'b0;
      level_q         <= 2'd0;
      table_ppn_q     <= '0;
      vpn_q           <= '0;
      asid_q          <= '0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_pa_q    <= '0;
      resp_valid_q    <= 1'b0;
      resp_vpn_q      <= '0;
      resp_asid_q     <= '0;
      resp_pte_q      <= '0;
      resp_level_q    <= 2'd0;
      resp_pf_q       <= 1'b0;
      resp_af_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      kill_q          <= kill_d;
      level_q         <= level_d;
      table_ppn_q     <= table_ppn_d;
      vpn_q           <= vpn_d;
      asid_q          <= asid_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_pa_q    <= mem_req_pa_d;
      resp_valid_q    <= resp_valid_d;
      resp_vpn_q      <= resp_vpn_d;
      resp_asid_q     <= resp_asid_d;
      resp_pte_q      <= resp_pte_d;
      resp_level_q    <= resp_level_d;
      resp_pf_q       <= resp_pf_d;
      resp_af_q       <= resp_af_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign mem_req_valid     = mem_req_valid_q;
  assign mem_req_pa        = mem_req_pa_q;
  assign resp_valid        = resp_valid_q;
  assign resp_vpn          = resp_vpn_q;
  assign resp_asid         = resp_asid_q;
  assign resp_pte          = resp_pte_q;
  assign resp_level        = resp_level_q;
  assign resp_page_fault   = resp_pf_q;
  assign resp_access_fault = resp_af_q;

endmodule
